// File: rtl/mem_resp_model.sv
// mem_resp_model: single-port memory responder with pipelined reads, stuck-at fault injection and access counters
module mem_resp_model #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         adrs,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    input  logic                      fault_en,
    input  logic [ADDR_W-1:0]         fault_adrs,
    input  logic [$clog2(DATA_W)-1:0] fault_bit,
    input  logic                      fault_val,
    input  logic                      clr_cnt,
    output logic [15:0]               wr_count,
    output logic [15:0]               rd_count
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] pd [RD_LAT];
    logic              pv [RD_LAT];
    logic [DATA_W-1:0] rd_word;
    logic              rd, wr;

    assign rd = req && !write;
    assign wr = req && write;

    // Storage is deliberately unreset so contents survive rst; the fault only corrupts the read path.
    always_ff @(posedge clk)
        if (rst && wr)
            mem[adrs] <= wdata;

    always_comb begin
        rd_word = mem[adrs];
        if (fault_en && adrs == fault_adrs)
            rd_word[fault_bit] = fault_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd;
            if (rd)
                pd[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1])
                    pd[i] <= pd[i-1];
            end
        end
    end

    assign rdata  = pd[RD_LAT-1];
    assign rvalid = pv[RD_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            wr_count <= clr_cnt ? 16'd0 : (wr && wr_count != 16'hFFFF) ? wr_count + 16'd1 : wr_count;
            rd_count <= clr_cnt ? 16'd0 : (rd && rd_count != 16'hFFFF) ? rd_count + 16'd1 : rd_count;
        end
    end
endmodule

// File: tb/tb_mem_resp_model.sv
// tb_mem_resp_model: three responders (latency 1..3) on shared random/directed stimulus vs. a transaction-level model
module tb_mem_resp_model;
    logic        clk = 1'b0;
    logic        rst, req, write, fault_en, fault_val, clr_cnt;
    logic [14:0] adrs, fault_adrs;
    logic [15:0] wdata;
    logic [3:0]  fault_bit;
    logic [15:0] rdata [3];
    logic        rvalid [3];
    logic [15:0] wrc [3];
    logic [15:0] rdc [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mem_resp_model #(.ADDR_W(15), .DATA_W(16), .RD_LAT(g + 1)) dut (
            .clk(clk), .rst(rst), .req(req), .write(write), .adrs(adrs), .wdata(wdata),
            .rdata(rdata[g]), .rvalid(rvalid[g]), .fault_en(fault_en), .fault_adrs(fault_adrs),
            .fault_bit(fault_bit), .fault_val(fault_val), .clr_cnt(clr_cnt),
            .wr_count(wrc[g]), .rd_count(rdc[g])
        );
    end

    int          n_chk = 0, n_err = 0;
    logic [15:0] m [logic [14:0]];
    int          k = 0, mw = 0, mr = 0;
    logic        iv [4];
    logic [15:0] id [4];
    logic        ev [3];
    logic [15:0] hold [3];
    logic [14:0] pool [8] = '{15'h0000, 15'h7FFF, 15'h0001, 15'h0002, 15'h0003, 15'h0123, 15'h0124, 15'h5555};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) iv[i] = 1'b0;
        for (int l = 0; l < 3; l++) begin
            ev[l] = 1'b0;
            hold[l] = 16'h0;
        end
        mw = 0;
        mr = 0;
    endtask

    // A read issued at edge N is visible after edge N+L-1, so each latency looks back L-1 edges.
    task automatic model_edge();
        logic [15:0] d;
        k++;
        iv[k % 4] = 1'b0;
        if (!rst) model_reset();
        else begin
            if (clr_cnt) begin
                mw = 0;
                mr = 0;
            end else if (req && write) mw = (mw == 65535) ? mw : mw + 1;
            else if (req) mr = (mr == 65535) ? mr : mr + 1;
            if (req && write) m[adrs] = wdata;
            else if (req) begin
                d = m[adrs];
                if (fault_en && adrs == fault_adrs) d[fault_bit] = fault_val;
                iv[k % 4] = 1'b1;
                id[k % 4] = d;
            end
        end
        for (int l = 0; l < 3; l++) begin
            ev[l] = iv[(k + 4 - l) % 4];
            if (ev[l]) hold[l] = id[(k + 4 - l) % 4];
        end
    endtask

    task automatic compare();
        for (int l = 0; l < 3; l++) begin
            check($sformatf("rvalid_lat%0d", l + 1), 32'(rvalid[l]), 32'(ev[l]));
            check($sformatf("rdata_lat%0d", l + 1), 32'(rdata[l]), 32'(hold[l]));
            check($sformatf("wr_count_lat%0d", l + 1), 32'(wrc[l]), mw);
            check($sformatf("rd_count_lat%0d", l + 1), 32'(rdc[l]), mr);
        end
    endtask

    task automatic step(input bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) compare();
    endtask

    task automatic op(input bit r, input bit w, input logic [14:0] a, input logic [15:0] d);
        req = r;
        write = w;
        adrs = a;
        wdata = d;
        step(1'b1);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; write = 1'b0; adrs = '0; wdata = '0;
        fault_en = 1'b0; fault_adrs = '0; fault_bit = '0; fault_val = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (3) step(1'b1);
        rst = 1'b1;
        op(1, 1, 15'h0000, 16'hA5A5);
        op(1, 1, 15'h7FFF, 16'h5A5A);
        op(1, 0, 15'h0000, 16'h0);
        op(1, 0, 15'h7FFF, 16'h0);
        repeat (4) op(0, 0, 15'h0, 16'h0);
        check("wr_count_after_2", 32'(wrc[0]), 32'd2);
        check("rd_count_after_2", 32'(rdc[0]), 32'd2);
        for (int i = 1; i <= 3; i++) op(1, 1, 15'(i), 16'(i));
        for (int i = 1; i <= 3; i++) op(1, 0, 15'(i), 16'h0);
        repeat (4) op(0, 0, 15'h0, 16'h0);
        op(1, 1, 15'h0123, 16'h0000);
        op(1, 1, 15'h0124, 16'h0000);
        fault_en = 1'b1; fault_adrs = 15'h0123; fault_bit = 4'd7; fault_val = 1'b1;
        op(1, 0, 15'h0123, 16'h0);
        op(1, 0, 15'h0124, 16'h0);
        fault_en = 1'b0;
        op(1, 0, 15'h0123, 16'h0);
        repeat (3) op(0, 0, 15'h0, 16'h0);
        check("fault_cleared_rdata", 32'(rdata[2]), 32'h0000);
        op(1, 0, 15'h0123, 16'h0);
        fault_en = 1'b1;
        op(1, 0, 15'h0123, 16'h0);
        fault_en = 1'b0;
        repeat (3) op(0, 0, 15'h0, 16'h0);
        op(1, 1, 15'h0002, 16'hBEEF);
        op(1, 0, 15'h0002, 16'h0);
        req = 1'b0;
        #4;
        rst = 1'b0;
        model_reset();
        #1;
        compare();
        repeat (2) step(1'b1);
        rst = 1'b1;
        op(1, 0, 15'h0002, 16'h0);
        repeat (3) op(0, 0, 15'h0, 16'h0);
        check("after_reset_read", 32'(rdata[1]), 32'hBEEF);
        op(1, 1, 15'h5555, 16'h1234);
        for (int i = 0; i < 400; i++) begin
            fault_en   = ($urandom_range(2) == 0);
            fault_adrs = pool[$urandom_range(7)];
            fault_bit  = 4'($urandom_range(15));
            fault_val  = 1'($urandom);
            clr_cnt    = ($urandom_range(15) == 0);
            op($urandom_range(3) != 0, $urandom_range(2) == 0, pool[$urandom_range(7)], 16'($urandom));
        end
        fault_en = 1'b0;
        clr_cnt  = 1'b1;
        op(0, 0, 15'h0, 16'h0);
        clr_cnt = 1'b0;
        req = 1'b1; write = 1'b0; adrs = 15'h0001;
        for (int i = 0; i < 65540; i++) step(1'b0);
        op(0, 0, 15'h0, 16'h0);
        check("rd_count_saturated", 32'(rdc[0]), 32'hFFFF);
        clr_cnt = 1'b1;
        op(1, 0, 15'h0001, 16'h0);
        check("rd_count_clr_priority", 32'(rdc[2]), 32'h0);
        clr_cnt = 1'b0;
        repeat (3) op(0, 0, 15'h0, 16'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
